// File: rtl/tdp_ram_be.sv
// True dual-port RAM with byte enables, per-port write modes, configurable read
// latency with a valid pipeline, and same-address write-write collision tracking.
module tdp_ram_be #(
    parameter int DATA_WIDTH   = 64,
    parameter int NUM_ENTRIES  = 2048,
    parameter int ADDR_WIDTH   = $clog2(NUM_ENTRIES),
    parameter int NUM_BYTES    = DATA_WIDTH / 8,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_MODE_A = 0,
    parameter int WRITE_MODE_B = 0,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  portA_en,
    input  logic [ADDR_WIDTH-1:0] portA_addr,
    input  logic [NUM_BYTES-1:0]  portA_we,
    input  logic [DATA_WIDTH-1:0] portA_din,
    output logic [DATA_WIDTH-1:0] portA_dout,
    output logic                  portA_dout_valid,
    input  logic                  portB_en,
    input  logic [ADDR_WIDTH-1:0] portB_addr,
    input  logic [NUM_BYTES-1:0]  portB_we,
    input  logic [DATA_WIDTH-1:0] portB_din,
    output logic [DATA_WIDTH-1:0] portB_dout,
    output logic                  portB_dout_valid,
    output logic                  collision,
    output logic [CNT_WIDTH-1:0]  collision_cnt,
    input  logic                  collision_clr
);

    localparam int MODE_WF = 1;
    localparam int MODE_NC = 2;
    localparam int LAT = (READ_LATENCY < 1) ? 1 : ((READ_LATENCY > 4) ? 4 : READ_LATENCY);
    localparam logic [ADDR_WIDTH:0]  DEPTH   = (ADDR_WIDTH + 1)'(NUM_ENTRIES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0] mem [NUM_ENTRIES];

    logic                  en_s     [2];
    logic [ADDR_WIDTH-1:0] addr_s   [2];
    logic [NUM_BYTES-1:0]  we_s     [2];
    logic [DATA_WIDTH-1:0] din_s    [2];
    logic                  hit_s    [2];
    logic                  wr_s     [2];
    logic                  wr_en_s  [2];
    logic [DATA_WIDTH-1:0] old_s    [2];
    logic [DATA_WIDTH-1:0] new_s    [2];
    logic [DATA_WIDTH-1:0] fin_s    [2];
    logic                  rd_vld_s [2];
    logic [DATA_WIDTH-1:0] rd_dat_s [2];
    logic                  col_s;

    logic                  vld_d [2][LAT];
    logic                  vld_q [2][LAT];
    logic [DATA_WIDTH-1:0] dat_d [2][LAT];
    logic [DATA_WIDTH-1:0] dat_q [2][LAT];
    logic                  collision_d;
    logic                  collision_q;
    logic [CNT_WIDTH-1:0]  cnt_d;
    logic [CNT_WIDTH-1:0]  cnt_q;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] base,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [NUM_BYTES-1:0]  we
    );
        logic [DATA_WIDTH-1:0] res;
        res = base;
        for (int i = 0; i < NUM_BYTES; i++) begin
            res[8*i +: 8] = we[i] ? wdata[8*i +: 8] : base[8*i +: 8];
        end
        return res;
    endfunction

    function automatic int mode_of(input int p);
        return (p == 0) ? WRITE_MODE_A : WRITE_MODE_B;
    endfunction

    // Decode both ports: range check, old word, and per-port merged write word.
    always_comb begin
        en_s[0]   = portA_en;
        addr_s[0] = portA_addr;
        we_s[0]   = portA_we;
        din_s[0]  = portA_din;
        en_s[1]   = portB_en;
        addr_s[1] = portB_addr;
        we_s[1]   = portB_we;
        din_s[1]  = portB_din;
        for (int p = 0; p < 2; p++) begin
            hit_s[p] = en_s[p] && ({1'b0, addr_s[p]} < DEPTH);
            wr_s[p]  = hit_s[p] && (|we_s[p]);
            old_s[p] = hit_s[p] ? mem[addr_s[p]] : '0;
            new_s[p] = merge_bytes(old_s[p], din_s[p], we_s[p]);
        end
    end

    // Collision resolution: A is merged on top of B so A wins overlapping lanes;
    // the combined word is written once through port A.
    always_comb begin
        col_s      = wr_s[0] && wr_s[1] && (addr_s[0] == addr_s[1]);
        fin_s[0]   = col_s ? merge_bytes(new_s[1], din_s[0], we_s[0]) : new_s[0];
        fin_s[1]   = col_s ? fin_s[0] : new_s[1];
        wr_en_s[0] = wr_s[0];
        wr_en_s[1] = wr_s[1] && !col_s;
    end

    // Readback selection by write mode; cross-port reads always see the old word.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_vld_s[p] = en_s[p] && !((|we_s[p]) && (mode_of(p) == MODE_NC));
            rd_dat_s[p] = ((|we_s[p]) && (mode_of(p) == MODE_WF) && wr_s[p]) ? fin_s[p] : old_s[p];
        end
    end

    // Array update; no reset so contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (wr_en_s[0]) begin
            mem[addr_s[0]] <= fin_s[0];
        end
        if (wr_en_s[1]) begin
            mem[addr_s[1]] <= fin_s[1];
        end
    end

    // Read pipeline next state: each stage loads only on a valid so dout holds.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            vld_d[p][0] = rd_vld_s[p];
            dat_d[p][0] = rd_vld_s[p] ? rd_dat_s[p] : dat_q[p][0];
            for (int k = 1; k < LAT; k++) begin
                vld_d[p][k] = vld_q[p][k-1];
                dat_d[p][k] = vld_q[p][k-1] ? dat_q[p][k-1] : dat_q[p][k];
            end
        end
    end

    // Collision pulse and saturating counter next state; clear beats increment.
    always_comb begin
        collision_d = col_s;
        if (collision_clr) begin
            cnt_d = '0;
        end else if (col_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < 2; p++) begin
                for (int k = 0; k < LAT; k++) begin
                    vld_q[p][k] <= 1'b0;
                    dat_q[p][k] <= '0;
                end
            end
            collision_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            vld_q       <= vld_d;
            dat_q       <= dat_d;
            collision_q <= collision_d;
            cnt_q       <= cnt_d;
        end
    end

    assign portA_dout       = dat_q[0][LAT-1];
    assign portA_dout_valid = vld_q[0][LAT-1];
    assign portB_dout       = dat_q[1][LAT-1];
    assign portB_dout_valid = vld_q[1][LAT-1];
    assign collision        = collision_q;
    assign collision_cnt    = cnt_q;

endmodule

// File: tb/tb_tdp_ram_be.sv
// Directed bench for tdp_ram_be: three instances (latency 1/3/4, different write
// modes, narrow counter, non-power-of-2 depth) share one stimulus stream.
module tb_tdp_ram_be;

    localparam logic [63:0] K    = 64'h1122334455667788;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] P1   = 64'h0101010101010101;
    localparam logic [63:0] P2   = 64'h0202020202020202;
    localparam logic [63:0] W9   = 64'h11111111FFFFFFFF;
    localparam logic [63:0] W4   = 64'h0000000000004433;
    localparam logic [63:0] W7   = 64'h01010101010101AA;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        a_en, b_en, clr;
    logic [10:0] a_addr, b_addr;
    logic [7:0]  a_we, b_we;
    logic [63:0] a_din, b_din;

    logic [63:0] a_do [3];
    logic [63:0] b_do [3];
    logic        a_v  [3];
    logic        b_v  [3];
    logic        col  [3];
    logic [15:0] cnt0, cnt2;
    logic [1:0]  cnt1;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic        ae;  logic [10:0] aa; logic [7:0] aw; logic [63:0] ad;
        logic        be;  logic [10:0] ba; logic [7:0] bw; logic [63:0] bd;
        logic        cl;
        logic        eav; logic [63:0] ead;
        logic        ebv; logic [63:0] ebd;
        logic        ecol; logic [15:0] ecnt;
    } vec_t;

    vec_t tbl[$];

    always #5 clock = ~clock;

    // u0: latency 1, A read-first, B write-first
    tdp_ram_be #(.READ_LATENCY(1), .WRITE_MODE_A(0), .WRITE_MODE_B(1)) u0 (
        .clock(clock), .reset(rst_n),
        .portA_en(a_en), .portA_addr(a_addr), .portA_we(a_we), .portA_din(a_din),
        .portA_dout(a_do[0]), .portA_dout_valid(a_v[0]),
        .portB_en(b_en), .portB_addr(b_addr), .portB_we(b_we), .portB_din(b_din),
        .portB_dout(b_do[0]), .portB_dout_valid(b_v[0]),
        .collision(col[0]), .collision_cnt(cnt0), .collision_clr(clr));

    // u1: latency 3, A no-change, B read-first, 2-bit counter
    tdp_ram_be #(.READ_LATENCY(3), .WRITE_MODE_A(2), .WRITE_MODE_B(0), .CNT_WIDTH(2)) u1 (
        .clock(clock), .reset(rst_n),
        .portA_en(a_en), .portA_addr(a_addr), .portA_we(a_we), .portA_din(a_din),
        .portA_dout(a_do[1]), .portA_dout_valid(a_v[1]),
        .portB_en(b_en), .portB_addr(b_addr), .portB_we(b_we), .portB_din(b_din),
        .portB_dout(b_do[1]), .portB_dout_valid(b_v[1]),
        .collision(col[1]), .collision_cnt(cnt1), .collision_clr(clr));

    // u2: latency 4, 1000 entries, A write-first, B no-change
    tdp_ram_be #(.NUM_ENTRIES(1000), .READ_LATENCY(4), .WRITE_MODE_A(1), .WRITE_MODE_B(2)) u2 (
        .clock(clock), .reset(rst_n),
        .portA_en(a_en), .portA_addr(a_addr[9:0]), .portA_we(a_we), .portA_din(a_din),
        .portA_dout(a_do[2]), .portA_dout_valid(a_v[2]),
        .portB_en(b_en), .portB_addr(b_addr[9:0]), .portB_we(b_we), .portB_din(b_din),
        .portB_dout(b_do[2]), .portB_dout_valid(b_v[2]),
        .collision(col[2]), .collision_cnt(cnt2), .collision_clr(clr));

    function automatic vec_t mkv(
        input logic ae, input logic [10:0] aa, input logic [7:0] aw, input logic [63:0] ad,
        input logic be, input logic [10:0] ba, input logic [7:0] bw, input logic [63:0] bd,
        input logic cl, input logic eav, input logic [63:0] ead,
        input logic ebv, input logic [63:0] ebd, input logic ecol, input logic [15:0] ecnt);
        vec_t v;
        v.ae = ae; v.aa = aa; v.aw = aw; v.ad = ad;
        v.be = be; v.ba = ba; v.bw = bw; v.bd = bd;
        v.cl = cl; v.eav = eav; v.ead = ead; v.ebv = ebv; v.ebd = ebd;
        v.ecol = ecol; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        a_en = 1'b0; a_addr = 11'd0; a_we = 8'h00; a_din = 64'd0;
        b_en = 1'b0; b_addr = 11'd0; b_we = 8'h00; b_din = 64'd0;
        clr  = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s u%0d a_vld", tag, i), 64'(a_v[i]), 64'd0);
            chk($sformatf("%s u%0d b_vld", tag, i), 64'(b_v[i]), 64'd0);
            chk($sformatf("%s u%0d a_dout", tag, i), a_do[i], 64'd0);
            chk($sformatf("%s u%0d b_dout", tag, i), b_do[i], 64'd0);
            chk($sformatf("%s u%0d col", tag, i), 64'(col[i]), 64'd0);
        end
        chk({tag, " u0 cnt"}, 64'(cnt0), 64'd0);
        chk({tag, " u1 cnt"}, 64'(cnt1), 64'd0);
        chk({tag, " u2 cnt"}, 64'(cnt2), 64'd0);
    endtask

    initial begin
        logic [10:0] rd_addr [3];
        logic [63:0] rd_exp  [3];
        rd_addr[0] = 11'd5; rd_addr[1] = 11'd9; rd_addr[2] = 11'd4;
        rd_exp[0]  = K;     rd_exp[1]  = W9;    rd_exp[2]  = W4;

        //               ae    aa      aw     ad            be    ba      bw     bd                   cl    eav   ead          ebv   ebd   ecol  ecnt
        tbl.push_back(mkv(1'b0, 11'd0, 8'h00, 64'd0,        1'b1, 11'd5, 8'hFF, 64'd0,               1'b0, 1'b0, 64'd0,       1'b1, 64'd0,   1'b0, 16'd0));
        tbl.push_back(mkv(1'b0, 11'd0, 8'h00, 64'd0,        1'b1, 11'd9, 8'hFF, 64'd0,               1'b0, 1'b0, 64'd0,       1'b1, 64'd0,   1'b0, 16'd0));
        tbl.push_back(mkv(1'b0, 11'd0, 8'h00, 64'd0,        1'b1, 11'd2, 8'hFF, 64'hAA,              1'b0, 1'b0, 64'd0,       1'b1, 64'hAA,  1'b0, 16'd0));
        tbl.push_back(mkv(1'b0, 11'd0, 8'h00, 64'd0,        1'b1, 11'd7, 8'hFF, 64'd0,               1'b0, 1'b0, 64'd0,       1'b1, 64'd0,   1'b0, 16'd0));
        tbl.push_back(mkv(1'b0, 11'd0, 8'h00, 64'd0,        1'b1, 11'd4, 8'hFF, 64'h10,              1'b0, 1'b0, 64'd0,       1'b1, 64'h10,  1'b0, 16'd0));
        tbl.push_back(mkv(1'b1, 11'd5, 8'hFF, K,            1'b0, 11'd0, 8'h00, 64'd0,               1'b0, 1'b1, 64'd0,       1'b0, 64'h10,  1'b0, 16'd0));
        tbl.push_back(mkv(1'b0, 11'd0, 8'h00, 64'd0,        1'b1, 11'd5, 8'h00, 64'd0,               1'b0, 1'b0, 64'd0,       1'b1, K,       1'b0, 16'd0));
        tbl.push_back(mkv(1'b1, 11'd9, 8'h0F, ONES,         1'b0, 11'd0, 8'h00, 64'd0,               1'b0, 1'b1, 64'd0,       1'b0, K,       1'b0, 16'd0));
        tbl.push_back(mkv(1'b1, 11'd9, 8'h00, 64'd0,        1'b0, 11'd0, 8'h00, 64'd0,               1'b0, 1'b1, 64'h00000000FFFFFFFF, 1'b0, K, 1'b0, 16'd0));
        tbl.push_back(mkv(1'b0, 11'd0, 8'h00, 64'd0,        1'b1, 11'd2, 8'hFF, 64'hBB,              1'b0, 1'b0, 64'h00000000FFFFFFFF, 1'b1, 64'hBB, 1'b0, 16'd0));
        tbl.push_back(mkv(1'b1, 11'd2, 8'hFF, 64'hAA,       1'b0, 11'd0, 8'h00, 64'd0,               1'b0, 1'b1, 64'hBB,      1'b0, 64'hBB,  1'b0, 16'd0));
        tbl.push_back(mkv(1'b0, 11'd0, 8'h00, 64'd0,        1'b1, 11'd9, 8'hF0, 64'h1111111111111111, 1'b0, 1'b0, 64'hBB,     1'b1, W9,      1'b0, 16'd0));
        tbl.push_back(mkv(1'b1, 11'd7, 8'hFF, P1,           1'b1, 11'd7, 8'hF0, P2,                  1'b0, 1'b1, 64'd0,       1'b1, P1,      1'b1, 16'd1));
        tbl.push_back(mkv(1'b0, 11'd0, 8'h00, 64'd0,        1'b1, 11'd7, 8'h00, 64'd0,               1'b0, 1'b0, 64'd0,       1'b1, P1,      1'b0, 16'd1));
        tbl.push_back(mkv(1'b1, 11'd4, 8'hFF, 64'h20,       1'b1, 11'd4, 8'h00, 64'd0,               1'b0, 1'b1, 64'h10,      1'b1, 64'h10,  1'b0, 16'd1));
        tbl.push_back(mkv(1'b0, 11'd0, 8'h00, 64'd0,        1'b1, 11'd4, 8'h00, 64'd0,               1'b0, 1'b0, 64'h10,      1'b1, 64'h20,  1'b0, 16'd1));
        tbl.push_back(mkv(1'b1, 11'd4, 8'h01, 64'h33,       1'b1, 11'd4, 8'h02, 64'h4400,            1'b0, 1'b1, 64'h20,      1'b1, W4,      1'b1, 16'd2));
        tbl.push_back(mkv(1'b0, 11'd0, 8'h00, 64'd0,        1'b1, 11'd4, 8'h00, 64'd0,               1'b1, 1'b0, 64'h20,      1'b1, W4,      1'b0, 16'd0));
        tbl.push_back(mkv(1'b1, 11'd7, 8'h01, 64'hAA,       1'b1, 11'd7, 8'h01, 64'hBB,              1'b1, 1'b1, P1,          1'b1, W7,      1'b1, 16'd0));
        tbl.push_back(mkv(1'b0, 11'd7, 8'hFF, ONES,         1'b0, 11'd7, 8'hFF, ONES,                1'b0, 1'b0, P1,          1'b0, W7,      1'b0, 16'd0));
        tbl.push_back(mkv(1'b0, 11'd0, 8'h00, 64'd0,        1'b1, 11'd7, 8'h00, 64'd0,               1'b0, 1'b0, P1,          1'b1, W7,      1'b0, 16'd0));
        tbl.push_back(mkv(1'b1, 11'd7, 8'h00, 64'd0,        1'b1, 11'd7, 8'h00, 64'd0,               1'b0, 1'b1, W7,          1'b1, W7,      1'b0, 16'd0));

        rst_n = 1'b0;
        idle();
        repeat (2) step();
        chk_zero("reset");
        rst_n = 1'b1;
        step();

        foreach (tbl[i]) begin
            a_en = tbl[i].ae; a_addr = tbl[i].aa; a_we = tbl[i].aw; a_din = tbl[i].ad;
            b_en = tbl[i].be; b_addr = tbl[i].ba; b_we = tbl[i].bw; b_din = tbl[i].bd;
            clr  = tbl[i].cl;
            step();
            chk($sformatf("row%0d a_vld", i), 64'(a_v[0]), 64'(tbl[i].eav));
            chk($sformatf("row%0d a_dout", i), a_do[0], tbl[i].ead);
            chk($sformatf("row%0d b_vld", i), 64'(b_v[0]), 64'(tbl[i].ebv));
            chk($sformatf("row%0d b_dout", i), b_do[0], tbl[i].ebd);
            chk($sformatf("row%0d col", i), 64'(col[0]), 64'(tbl[i].ecol));
            chk($sformatf("row%0d cnt", i), 64'(cnt0), 64'(tbl[i].ecnt));
        end
        idle();
        repeat (5) step();

        // Latency 1/3/4 and back-to-back reads on port B
        for (int k = 1; k <= 7; k++) begin
            if (k <= 3) begin
                b_en = 1'b1; b_addr = rd_addr[k-1]; b_we = 8'h00;
            end else begin
                idle();
            end
            step();
            chk($sformatf("lat k%0d u0 b_vld", k), 64'(b_v[0]), 64'(k <= 3));
            chk($sformatf("lat k%0d u1 b_vld", k), 64'(b_v[1]), 64'(k >= 3 && k <= 5));
            chk($sformatf("lat k%0d u2 b_vld", k), 64'(b_v[2]), 64'(k >= 4 && k <= 6));
            if (k <= 3) chk($sformatf("lat k%0d u0 b_dout", k), b_do[0], rd_exp[k-1]);
            if (k >= 3 && k <= 5) chk($sformatf("lat k%0d u1 b_dout", k), b_do[1], rd_exp[k-3]);
            if (k >= 4 && k <= 6) chk($sformatf("lat k%0d u2 b_dout", k), b_do[2], rd_exp[k-4]);
        end

        // Same-port write on address 2 under read-first / no-change / write-first
        a_en = 1'b1; a_addr = 11'd2; a_we = 8'h00;
        step();
        idle();
        repeat (4) step();
        chk("mode pre u1 a_dout", a_do[1], 64'hAA);
        a_en = 1'b1; a_addr = 11'd2; a_we = 8'hFF; a_din = 64'hBB;
        for (int k = 1; k <= 5; k++) begin
            step();
            idle();
            chk($sformatf("mode k%0d u0 a_vld", k), 64'(a_v[0]), 64'(k == 1));
            chk($sformatf("mode k%0d u0 a_dout", k), a_do[0], 64'hAA);
            chk($sformatf("mode k%0d u1 a_vld", k), 64'(a_v[1]), 64'd0);
            chk($sformatf("mode k%0d u1 a_dout", k), a_do[1], 64'hAA);
            chk($sformatf("mode k%0d u2 a_vld", k), 64'(a_v[2]), 64'(k == 4));
            if (k >= 4) chk($sformatf("mode k%0d u2 a_dout", k), a_do[2], 64'hBB);
        end
        a_en = 1'b1; a_addr = 11'd2; a_we = 8'h00;
        step();
        idle();
        repeat (2) step();
        chk("mode post u1 a_vld", 64'(a_v[1]), 64'd1);
        chk("mode post u1 a_dout", a_do[1], 64'hBB);

        // Counter saturation on the 2-bit instance, then clear
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("sat pre u0 cnt", 64'(cnt0), 64'd0);
        chk("sat pre u1 cnt", 64'(cnt1), 64'd0);
        for (int k = 1; k <= 5; k++) begin
            a_en = 1'b1; a_addr = 11'd7; a_we = 8'hFF; a_din = P1;
            b_en = 1'b1; b_addr = 11'd7; b_we = 8'hFF; b_din = P2;
            step();
            chk($sformatf("sat k%0d u0 col", k), 64'(col[0]), 64'd1);
            chk($sformatf("sat k%0d u0 cnt", k), 64'(cnt0), 64'(k));
            chk($sformatf("sat k%0d u1 cnt", k), 64'(cnt1), 64'((k > 3) ? 3 : k));
        end
        idle();
        step();
        chk("sat idle u0 col", 64'(col[0]), 64'd0);
        chk("sat idle u1 cnt", 64'(cnt1), 64'd3);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("sat clr u0 cnt", 64'(cnt0), 64'd0);
        chk("sat clr u1 cnt", 64'(cnt1), 64'd0);

        // Address 1000 is out of range only for the 1000-entry instance
        a_en = 1'b1; a_addr = 11'd1000; a_we = 8'hFF; a_din = 64'hDEAD;
        b_en = 1'b1; b_addr = 11'd1000; b_we = 8'hFF; b_din = 64'hBEEF;
        step();
        idle();
        chk("oor u2 col", 64'(col[2]), 64'd0);
        chk("oor u2 cnt", 64'(cnt2), 64'd0);
        chk("oor u0 col", 64'(col[0]), 64'd1);
        chk("oor u0 cnt", 64'(cnt0), 64'd1);
        b_en = 1'b1; b_addr = 11'd1000; b_we = 8'h00;
        for (int k = 1; k <= 4; k++) begin
            step();
            idle();
            chk($sformatf("oor k%0d u2 b_vld", k), 64'(b_v[2]), 64'(k == 4));
            if (k == 1) chk("oor u0 b_dout", b_do[0], 64'hDEAD);
            if (k == 4) chk("oor u2 b_dout", b_do[2], 64'd0);
        end

        // Reset with reads in flight on the latency-4 instance
        for (int k = 0; k < 3; k++) begin
            a_en = 1'b1; a_addr = rd_addr[k]; a_we = 8'h00;
            step();
        end
        idle();
        step();
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        repeat (2) step();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("post k%0d u2 a_vld", k), 64'(a_v[2]), 64'd0);
            chk($sformatf("post k%0d u2 a_dout", k), a_do[2], 64'd0);
            chk($sformatf("post k%0d u1 a_vld", k), 64'(a_v[1]), 64'd0);
        end
        a_en = 1'b1; a_addr = 11'd5; a_we = 8'h00;
        for (int k = 1; k <= 4; k++) begin
            step();
            idle();
            chk($sformatf("keep k%0d u2 a_vld", k), 64'(a_v[2]), 64'(k == 4));
            if (k == 1) chk("keep u0 a_dout", a_do[0], K);
            if (k == 4) chk("keep u2 a_dout", a_do[2], K);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
